// File: rtl/conv1_event_sched.sv
// ---------------------------------------------------------------------------
// conv1_event_sched
//
// Arbitrates NUM_REQ event FIFOs onto the single conv1 weight-search port.
// Each delivered event walks ARB -> RD -> LAT -> OUT. A requester that keeps
// data may hold the path for up to BURST_MAX consecutive grants. After that,
// or as soon as it runs empty, the search goes round-robin starting at the
// requester after it. A frame opens on frame_start. frame_end only marks the
// frame as ending; the frame closes with a frame_done pulse once every FIFO
// has been drained.
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   fifo_empty[k]        requester k has no data
//   fifo_r_en[k]         one-cycle read strobe, one-hot or zero
//   fifo_data            requester k word at [k*POS_W +: POS_W], one cycle
//                        after its read strobe
//   out_valid/out_ready  handshake towards the weight-search unit
//   out_data, out_src    granted event word and the requester it came from
//   frame_start/end      single-cycle frame control pulses
//   frame_done           single-cycle pulse when a frame has been drained
//   busy                 high whenever not idle
//   evt_count            events delivered in the current frame (saturating)
// ---------------------------------------------------------------------------
module conv1_event_sched #(
  parameter int NUM_REQ   = 4,
  parameter int POS_W     = 23,
  parameter int BURST_MAX = 8,
  localparam int SRC_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       fifo_empty,
  output logic [NUM_REQ-1:0]       fifo_r_en,
  input  logic [NUM_REQ*POS_W-1:0] fifo_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [POS_W-1:0]         out_data,
  output logic [SRC_W-1:0]         out_src,
  input  logic                     frame_start,
  input  logic                     frame_end,
  output logic                     frame_done,
  output logic                     busy,
  output logic [15:0]              evt_count
);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    RD,
    LAT,
    OUT,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] last;
  logic             has_last;
  logic [7:0]       burst_cnt;
  logic             end_pending;

  logic             lock;
  logic             rr_found;
  logic [SRC_W-1:0] rr_idx;
  logic [SRC_W-1:0] arb_idx;
  logic             grant_ok;

  // Requester that sits 'off' positions after 'base', wrapping at NUM_REQ.
  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                input int off);
    int sum;
    sum = (int'(base) + off) % NUM_REQ;
    return SRC_W'(sum);
  endfunction

  // The current holder keeps the path only while it still has data and has
  // burst budget left. Once it runs empty the lock drops in the same cycle.
  assign lock = has_last && !fifo_empty[last] && (burst_cnt < 8'(BURST_MAX));

  // The round-robin search covers last+1 .. last+NUM_REQ. The final step
  // comes back to 'last' itself, so a requester whose burst is used up is
  // still served when it is the only one with data.
  // NOTE: every always_comb output gets a default before any branch so that
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!rr_found && !fifo_empty[wrap_add(last, i)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_add(last, i);
      end
    end
  end

  assign arb_idx  = lock ? last : rr_idx;
  assign grant_ok = lock || rr_found;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (frame_start) state_nxt = ARB;
      ARB: begin
        if (grant_ok)         state_nxt = RD;
        else if (end_pending) state_nxt = DONE;
      end
      RD:   state_nxt = LAT;
      LAT:  state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = ARB;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from the state register. A reset therefore
  // clears them in the same cycle, and any captured event is dropped.
  always_comb begin
    fifo_r_en = '0;
    if (state == RD) fifo_r_en[grant] = 1'b1;
  end

  assign out_valid  = (state == OUT);
  assign frame_done = (state == DONE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant       <= '0;
      last        <= SRC_W'(NUM_REQ - 1);
      has_last    <= 1'b0;
      burst_cnt   <= '0;
      end_pending <= 1'b0;
      out_data    <= '0;
      out_src     <= '0;
      evt_count   <= '0;
    end else begin
      if (state == IDLE && frame_start)    end_pending <= 1'b0;
      else if (state != IDLE && frame_end) end_pending <= 1'b1;

      if (state == ARB && grant_ok) begin
        grant <= arb_idx;
        if (has_last && arb_idx == last) begin
          // Saturating at BURST_MAX: any value at or above it means the
          // burst budget is used up.
          if (burst_cnt < 8'(BURST_MAX)) burst_cnt <= burst_cnt + 8'd1;
        end else begin
          burst_cnt <= 8'd1;
          last      <= arb_idx;
          has_last  <= 1'b1;
        end
      end

      // The FIFO word arrives one cycle after its read strobe, and that is
      // the cycle spent in LAT.
      if (state == LAT) begin
        out_data <= fifo_data[grant*POS_W +: POS_W];
        out_src  <= grant;
      end

      if (state == IDLE && frame_start) begin
        evt_count <= '0;
      end else if (state == OUT && out_ready && evt_count != 16'hFFFF) begin
        evt_count <= evt_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv1_event_sched.sv
// ---------------------------------------------------------------------------
// tb_conv1_event_sched
//
// Self-checking bench for conv1_event_sched. The bench models the FIFOs with
// queues. A reference model works out the whole grant order of a frame from
// the FIFO contents and the arbitration rules. The monitor records each
// delivered event and compares it against that order. It also checks strobe
// shape, output stability under back-pressure, throughput, frame_done
// behaviour, evt_count, and reset.
// ---------------------------------------------------------------------------
module tb_conv1_event_sched;

  localparam int NUM_REQ   = 4;
  localparam int POS_W     = 23;
  localparam int BURST_MAX = 8;
  localparam int SRC_W     = 2;

  typedef struct {
    logic [SRC_W-1:0] src;
    logic [POS_W-1:0] data;
  } evt_t;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic [NUM_REQ-1:0]       fifo_empty = '1;
  logic [NUM_REQ-1:0]       fifo_r_en;
  logic [NUM_REQ*POS_W-1:0] fifo_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [POS_W-1:0]         out_data;
  logic [SRC_W-1:0]         out_src;
  logic                     frame_start = 1'b0;
  logic                     frame_end = 1'b0;
  logic                     frame_done;
  logic                     busy;
  logic [15:0]              evt_count;

  conv1_event_sched #(
    .NUM_REQ  (NUM_REQ),
    .POS_W    (POS_W),
    .BURST_MAX(BURST_MAX)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .frame_done (frame_done),
    .busy       (busy),
    .evt_count  (evt_count)
  );

  initial forever #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // FIFO contents and their expected grant order
  logic [POS_W-1:0] q  [NUM_REQ][$];
  logic [POS_W-1:0] mq [NUM_REQ][$];
  evt_t exp_q[$];
  evt_t got_q[$];
  int   hs_cyc[$];

  // Arbiter state as the reference model sees it (persists across frames)
  int m_last;
  bit m_has;
  int m_cnt;

  // Monitor state
  int               cyc      = 0;
  int               rd_total = 0;
  int               done_cnt = 0;
  int               stall_obs = 0;
  bit               end_on_last = 0;
  bit               hold = 0;
  logic [POS_W-1:0] hold_data;
  logic [SRC_W-1:0] hold_src;
  logic [NUM_REQ-1:0] rd_pend;

  task automatic model_reset();
    m_last = NUM_REQ - 1;
    m_has  = 0;
    m_cnt  = 0;
  endtask

  // Works out the full delivery order of the frame from the queue contents.
  task automatic build_expected();
    int   pick;
    bit   any;
    evt_t e;
    exp_q.delete();
    for (int k = 0; k < NUM_REQ; k++) mq[k] = q[k];
    forever begin
      any = 0;
      for (int k = 0; k < NUM_REQ; k++) if (mq[k].size() > 0) any = 1;
      if (!any) break;
      pick = -1;
      if (m_has && mq[m_last].size() > 0 && m_cnt < BURST_MAX) pick = m_last;
      else
        for (int i = 1; i <= NUM_REQ; i++)
          if (pick < 0 && mq[(m_last + i) % NUM_REQ].size() > 0) pick = (m_last + i) % NUM_REQ;
      if (m_has && pick == m_last) begin
        if (m_cnt < BURST_MAX) m_cnt++;
      end else begin
        m_cnt = 1;
      end
      m_last = pick;
      m_has  = 1;
      e.src  = SRC_W'(pick);
      e.data = mq[pick].pop_front();
      exp_q.push_back(e);
    end
  endtask

  task automatic load(input int k, input int n);
    for (int i = 0; i < n; i++) q[k].push_back(POS_W'($urandom));
    if (n > 0) fifo_empty[k] = 1'b0;
  endtask

  // One clock: sample at the falling edge, then service FIFO reads and clear
  // the frame pulses just after the rising edge.
  task automatic tick();
    @(negedge clk);
    rd_pend = fifo_r_en;
    if (fifo_r_en != '0) begin
      rd_total++;
      checks++;
      if (!$onehot(fifo_r_en) || out_valid) begin
        failures++;
        $display("FAIL rd_strobe: fifo_r_en=%b out_valid=%b, required one-hot with no pending output",
                 fifo_r_en, out_valid);
      end
    end
    if (hold) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold_data || out_src !== hold_src) begin
        failures++;
        $display("FAIL out_stable: valid=%b data=%h src=%0d, required valid=1 data=%h src=%0d",
                 out_valid, out_data, out_src, hold_data, hold_src);
      end
    end
    if (out_valid && out_ready) begin
      got_q.push_back('{src: out_src, data: out_data});
      hs_cyc.push_back(cyc);
      hold = 0;
      if (end_on_last && got_q.size() == exp_q.size()) frame_end = 1'b1;
    end else if (out_valid) begin
      hold      = 1;
      hold_data = out_data;
      hold_src  = out_src;
      stall_obs++;
    end else begin
      hold = 0;
    end
    if (frame_done) done_cnt++;
    @(posedge clk);
    cyc++;
    #1;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rd_pend[k]) begin
        if (q[k].size() > 0) fifo_data[k*POS_W +: POS_W] = q[k].pop_front();
        else begin
          checks++;
          failures++;
          $display("FAIL read_empty: read strobe on requester %0d, required no read of an empty FIFO", k);
        end
      end
      fifo_empty[k] = (q[k].size() == 0);
    end
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    out_ready   = 1'b0;
    fifo_data   = '0;
    fifo_empty  = '1;
    for (int k = 0; k < NUM_REQ; k++) q[k].delete();
    model_reset();
    hold = 0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // mode: 0 random out_ready, 1 always ready, 2 ten-cycle stall then ready
  // end_mode: 0 frame_end at cycle end_cyc, 1 with the last handshake
  task automatic run_frame(input int mode, input int end_mode, input int end_cyc);
    int n;
    build_expected();
    if (exp_q.size() == 0) end_mode = 0;
    got_q.delete();
    hs_cyc.delete();
    done_cnt    = 0;
    stall_obs   = 0;
    rd_total    = 0;
    hold        = 0;
    end_on_last = (end_mode == 1);
    frame_start = 1'b1;
    out_ready   = (mode == 1);
    tick();
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      if (end_mode == 0 && n == end_cyc) frame_end = 1'b1;
      if (n == 5 && exp_q.size() >= 2) frame_start = 1'b1;
      case (mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = (stall_obs >= 10);
      endcase
      tick();
      n++;
    end
    end_on_last = 0;
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL frame_done_seen: pulses=%0d within %0d cycles, required 1", done_cnt, n);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_done: busy=%b, required 0", busy);
    end
    checks++;
    if (evt_count !== 16'(exp_q.size())) begin
      failures++;
      $display("FAIL evt_count: got %0d, required %0d", evt_count, exp_q.size());
    end
    checks++;
    if (got_q.size() != exp_q.size() || rd_total != exp_q.size()) begin
      failures++;
      $display("FAIL event_count: delivered %0d reads %0d, required %0d",
               got_q.size(), rd_total, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i].src !== exp_q[i].src || got_q[i].data !== exp_q[i].data) begin
        failures++;
        $display("FAIL event[%0d]: src=%0d data=%h, required src=%0d data=%h",
                 i, got_q[i].src, got_q[i].data, exp_q[i].src, exp_q[i].data);
      end
    end
    if (mode == 1)
      for (int i = 1; i < hs_cyc.size(); i++) begin
        checks++;
        if (hs_cyc[i] - hs_cyc[i-1] != 4) begin
          failures++;
          $display("FAIL throughput[%0d]: %0d cycles between events, required 4",
                   i, hs_cyc[i] - hs_cyc[i-1]);
        end
      end
    if (mode == 2) begin
      checks++;
      if (stall_obs < 10) begin
        failures++;
        $display("FAIL stall_hold: valid held %0d cycles under back-pressure, required 10", stall_obs);
      end
    end
    repeat (3) tick();
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL done_once: pulses=%0d busy=%b, required 1 and 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    checks++;
    if (fifo_r_en !== '0 || out_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: r_en=%b valid=%b done=%b busy=%b, required all 0",
               fifo_r_en, out_valid, frame_done, busy);
    end
    checks++;
    if (out_data !== '0 || out_src !== '0 || evt_count !== '0) begin
      failures++;
      $display("FAIL reset_data: data=%h src=%0d count=%0d, required 0",
               out_data, out_src, evt_count);
    end
    do_reset();
    // Data but no frame_start: nothing may be read.
    load(0, 2);
    rd_total = 0;
    out_ready = 1'b1;
    frame_end = 1'b1;
    repeat (6) tick();
    checks++;
    if (rd_total != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore: reads=%0d busy=%b, required 0 and 0", rd_total, busy);
    end
  endtask

  task automatic test_single_fifo();
    do_reset();
    load(2, 3);
    run_frame(1, 0, 2);
  endtask

  task automatic test_burst();
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) load(k, 20);
    run_frame(1, 0, 1);
    checks++;
    if (got_q.size() < 40) begin
      failures++;
      $display("FAIL burst_len: delivered %0d, required at least 40", got_q.size());
    end
    for (int i = 0; i < 40 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].src !== SRC_W'((i / 8) % 4)) begin
        failures++;
        $display("FAIL burst_order[%0d]: src=%0d, required %0d", i, got_q[i].src, (i / 8) % 4);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    load(1, 3);
    load(3, 2);
    run_frame(2, 0, 1);
  endtask

  task automatic test_frame_end();
    do_reset();
    load(0, 2);
    load(3, 3);
    run_frame(0, 0, 1);
    checks++;
    if (evt_count !== 16'd5) begin
      failures++;
      $display("FAIL frame_end_count: evt_count=%0d, required 5", evt_count);
    end
  endtask

  task automatic test_end_on_last();
    do_reset();
    load(1, 2);
    load(2, 2);
    run_frame(1, 1, 0);
  endtask

  task automatic test_lock_drop();
    do_reset();
    load(0, 10);
    load(1, 3);
    load(3, 10);
    run_frame(0, 0, 3);
  endtask

  task automatic test_reset_in_lat();
    int n;
    do_reset();
    load(0, 4);
    rd_total    = 0;
    out_ready   = 1'b1;
    frame_start = 1'b1;
    tick();
    n = 0;
    while (rd_total == 0 && n < 20) begin
      tick();
      n++;
    end
    // We are now just after the edge that ends RD, so the DUT is in LAT.
    rstn = 1'b0;
    #1;
    checks++;
    if (rd_total != 1 || out_valid !== 1'b0 || fifo_r_en !== '0 || busy !== 1'b0 ||
        out_data !== '0 || evt_count !== '0) begin
      failures++;
      $display("FAIL reset_lat: reads=%0d valid=%b r_en=%b busy=%b data=%h count=%0d, required 1 0 0 0 0 0",
               rd_total, out_valid, fifo_r_en, busy, out_data, evt_count);
    end
    #1 rstn = 1'b1;
    model_reset();
    hold     = 0;
    rd_total = 0;
    got_q.delete();
    repeat (12) tick();
    checks++;
    if (rd_total != 0 || got_q.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_read: reads=%0d events=%0d busy=%b, required 0 0 0",
               rd_total, got_q.size(), busy);
    end
    // The leftover words are delivered by the next frame.
    run_frame(1, 0, 1);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < NUM_REQ; k++) load(k, $urandom_range(0, 12));
      run_frame(($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1), $urandom_range(0, 15));
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_fifo();
    test_burst();
    test_stall();
    test_frame_end();
    test_end_on_last();
    test_lock_drop();
    test_reset_in_lat();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv1_event_sched.md
CONV1_EVENT_SCHED -- requirements
Module: conv1_event_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of event FIFOs sharing the conv1 weight-search path (2..8).
REQ-002 SHALL have parameter POS_W, default 23: width of one packed event word {channel_i, rel_pos, channel_o, x, y}.
REQ-003 SHALL have parameter BURST_MAX, default 8: maximum consecutive grants to one requester while it stays non-empty (1..255).
REQ-004 SHALL have port clk, input, 1: system clock, all logic on rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port fifo_empty, input, NUM_REQ: per-requester FIFO empty flag.
REQ-007 SHALL have port fifo_r_en, output, NUM_REQ: per-requester FIFO read strobe, one-hot or zero.
REQ-008 SHALL have port fifo_data, input, NUM_REQ*POS_W: FIFO read data, requester k at bits [k*POS_W +: POS_W], valid one cycle after fifo_r_en.
REQ-009 SHALL have port out_valid, input/output direction output, 1: event available to the weight-search unit.
REQ-010 SHALL have port out_ready, input, 1: weight-search unit accepts event.
REQ-011 SHALL have port out_data, output, POS_W: granted event word.
REQ-012 SHALL have port out_src, output, clog2(NUM_REQ): index of the requester that supplied out_data.
REQ-013 SHALL have ports frame_start and frame_end, input, 1 each: single-cycle frame control pulses.
REQ-014 SHALL have ports frame_done (output, 1, single-cycle pulse), busy (output, 1), evt_count (output, 16, events delivered in current frame).

Function
REQ-015 SHALL implement FSM states IDLE, ARB, RD, LAT, OUT, DONE.
REQ-016 IDLE: busy=0; frame_start -> ARB, clear evt_count and end_pending; all other inputs ignored.
REQ-017 ARB: if lock condition holds, grant last requester; else round-robin search from (last+1) mod NUM_REQ over non-empty requesters; any grant -> RD.
REQ-018 Lock condition SHALL be: has_last=1 AND fifo_empty[last]=0 AND burst_cnt < BURST_MAX.
REQ-019 On grant to same requester burst_cnt SHALL increment (saturating); on grant to different requester burst_cnt SHALL be 1 and last updated.
REQ-020 ARB with all FIFOs empty: end_pending=1 -> DONE; else remain in ARB.
REQ-021 RD: fifo_r_en[grant]=1 for exactly one cycle -> LAT; fifo_r_en=0 in every other state.
REQ-022 LAT: capture fifo_data slice of grant into out_data, grant into out_src, set out_valid=1 -> OUT.
REQ-023 OUT: out_data/out_src stable while out_valid=1 and out_ready=0; on out_valid&out_ready: out_valid=0, evt_count+1 (saturate at 16'hFFFF) -> ARB.
REQ-024 Minimum event throughput SHALL be 4 cycles per event (ARB, RD, LAT, OUT with out_ready=1).
REQ-025 DONE: frame_done=1 for one cycle -> IDLE.
REQ-026 frame_end in any non-IDLE state SHALL set end_pending; frame_end in IDLE ignored; frame_start outside IDLE ignored.
REQ-027 frame_end coincident with final OUT handshake SHALL still be latched and lead to DONE on next empty ARB.
REQ-028 busy SHALL be 1 in ARB, RD, LAT, OUT, DONE.
REQ-029 Requester emptying during lock SHALL drop lock and fall to round-robin in same ARB cycle.

Reset
REQ-030 rstn low SHALL force immediately: state IDLE, fifo_r_en=0, out_valid=0, out_data=0, out_src=0, frame_done=0, busy=0, evt_count=0, burst_cnt=0, has_last=0, last=NUM_REQ-1, end_pending=0.
REQ-031 Reset asserted mid-transfer SHALL discard any captured event without handshake; no FIFO read SHALL issue until a new frame_start.

Verification
REQ-032 Reset, frame_start, only FIFO2 non-empty with 3 words A,B,C, out_ready=1 -> fifo_r_en=4'b0100 three times, out_data A,B,C with out_src=2, evt_count=3.
REQ-033 All 4 FIFOs hold 20 words, BURST_MAX=8 -> grants 8xreq0, 8xreq1, 8xreq2, 8xreq3, then 8xreq0 again.
REQ-034 out_ready held 0 for 10 cycles in OUT -> out_valid=1 and out_data unchanged throughout, no fifo_r_en pulse.
REQ-035 frame_end while FIFOs hold 5 words -> all 5 delivered, then frame_done pulse exactly once, busy=0 next cycle, evt_count=5.
REQ-036 Reset asserted in LAT -> out_valid=0 and fifo_r_en=0 same cycle; after release no read until frame_start.
REQ-037 Req1 FIFO empties after 3 grants while req3 non-empty -> next grant req3, burst_cnt=1.
